// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: round-robin sharer of one single-port data memory between
// the pipeline MEM stage (port A) and an auxiliary master (port B).
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   a_req_i..a_wdata_i  port A request: store when a_we_i, word address, store data
//   a_ack_o             one-cycle completion pulse for port A
//   a_rdata_o, a_err_o  load data / out-of-range flag, valid with a_ack_o
//   b_*                 same set for port B
//   stall_a_o           port A request still pending (freezes the pipeline)
//   busy_o              an access is in progress
//   mem_en_o..mem_wdata_o  single-cycle strobe, write enable, address, write data
//   mem_rdata_i         read data, valid MEM_LAT cycles after the strobe cycle
module mem_access_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LAT     = 2,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    output logic              a_ack_o,
    output logic [DATA_W-1:0] a_rdata_o,
    output logic              a_err_o,
    input  logic              b_req_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic              b_ack_o,
    output logic [DATA_W-1:0] b_rdata_o,
    output logic              b_err_o,
    output logic              stall_a_o,
    output logic              busy_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH_WORDS);
    localparam logic [3:0]        LAT_M1  = 4'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              owner_q, last_q, we_q;
    logic              grant_b_d, grant_d, issue_d, done_d, err_d, own_d;
    logic              sel_we_d;
    logic [ADDR_W-1:0] sel_addr_d;
    logic [DATA_W-1:0] sel_wdata_d, rdata_d;

    // owner/last_owner encoding: 0 = A, 1 = B; on a tie the port that did not
    // own the previous access wins
    assign grant_b_d   = b_req_i & (~a_req_i | ~last_q);
    assign sel_we_d    = grant_b_d ? b_we_i    : a_we_i;
    assign sel_addr_d  = grant_b_d ? b_addr_i  : a_addr_i;
    assign sel_wdata_d = grant_b_d ? b_wdata_i : a_wdata_i;
    // an out-of-range grant completes straight from IDLE, before owner_q is loaded
    assign own_d       = (state_q == S_IDLE) ? grant_b_d : owner_q;
    assign stall_a_o   = a_req_i & ~a_ack_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = 1'b0;
        issue_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
        case (state_q)
            S_IDLE: begin
                if (a_req_i | b_req_i) begin
                    grant_d = 1'b1;
                    if (sel_addr_d >= DEPTH_A) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        issue_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_d = we_q ? S_DONE : S_WAIT;
                done_d  = we_q;
                cnt_d   = LAT_M1;
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    rdata_d = mem_rdata_i;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // every output below is registered one cycle ahead of the state it belongs to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            we_q        <= 1'b0;
            a_ack_o     <= 1'b0;
            a_rdata_o   <= '0;
            a_err_o     <= 1'b0;
            b_ack_o     <= 1'b0;
            b_rdata_o   <= '0;
            b_err_o     <= 1'b0;
            busy_o      <= 1'b0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_o   <= state_d != S_IDLE;
            mem_en_o <= issue_d;
            mem_we_o <= issue_d & sel_we_d;
            if (grant_d) begin
                owner_q     <= grant_b_d;
                last_q      <= grant_b_d;
                we_q        <= sel_we_d;
                mem_addr_o  <= sel_addr_d;
                mem_wdata_o <= sel_wdata_d;
            end
            a_ack_o   <= done_d & ~own_d;
            a_err_o   <= err_d & ~own_d;
            a_rdata_o <= (done_d & ~own_d) ? rdata_d : '0;
            b_ack_o   <= done_d & own_d;
            b_err_o   <= err_d & own_d;
            b_rdata_o <= (done_d & own_d) ? rdata_d : '0;
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: directed bench for mem_access_arbiter at MEM_LAT 2, 1 and 5.
module tb_mem_access_arbiter;

    localparam int LAT [3] = '{2, 1, 5};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  a_req = '0;
    logic        a_we = 1'b0;
    logic [31:0] a_addr = '0, a_wdata = '0;
    logic        b_req = 1'b0, b_off = 1'b0;
    logic        b_we = 1'b0;
    logic [31:0] b_addr = '0, b_wdata = '0;

    logic [2:0]  a_ack, a_err, b_ack, b_err, stall, busy, me, mwe;
    logic [31:0] a_rdata [3];
    logic [31:0] b_rdata [3];
    logic [31:0] maddr [3];
    logic [31:0] mwdata [3];
    logic [31:0] mrdata [3];

    logic [31:0] mem [3][1024];
    logic        pend [3] = '{1'b0, 1'b0, 1'b0};
    int          rem [3] = '{0, 0, 0};
    logic [31:0] pdat [3];
    int          en_cnt [3] = '{0, 0, 0};
    logic [31:0] last_addr [3];
    logic        last_we [3];
    int          back_cnt = 0;

    int          checks = 0, errors = 0;
    int          n, en_d, nack, ovl, bcnt0;
    logic [31:0] rd;
    logic        er, st_ok;
    int          ord [4];
    logic [31:0] rds [4];
    logic [31:0] oth [4];

    always #5 clk = ~clk;

    mem_access_arbiter #(.MEM_LAT(2)) u2 (
        .clk(clk), .rst_n(rst_n),
        .a_req_i(a_req[0]), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_ack_o(a_ack[0]), .a_rdata_o(a_rdata[0]), .a_err_o(a_err[0]),
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_ack_o(b_ack[0]), .b_rdata_o(b_rdata[0]), .b_err_o(b_err[0]),
        .stall_a_o(stall[0]), .busy_o(busy[0]),
        .mem_en_o(me[0]), .mem_we_o(mwe[0]), .mem_addr_o(maddr[0]),
        .mem_wdata_o(mwdata[0]), .mem_rdata_i(mrdata[0]));

    mem_access_arbiter #(.MEM_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .a_req_i(a_req[1]), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_ack_o(a_ack[1]), .a_rdata_o(a_rdata[1]), .a_err_o(a_err[1]),
        .b_req_i(b_off), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_ack_o(b_ack[1]), .b_rdata_o(b_rdata[1]), .b_err_o(b_err[1]),
        .stall_a_o(stall[1]), .busy_o(busy[1]),
        .mem_en_o(me[1]), .mem_we_o(mwe[1]), .mem_addr_o(maddr[1]),
        .mem_wdata_o(mwdata[1]), .mem_rdata_i(mrdata[1]));

    mem_access_arbiter #(.MEM_LAT(5)) u5 (
        .clk(clk), .rst_n(rst_n),
        .a_req_i(a_req[2]), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_ack_o(a_ack[2]), .a_rdata_o(a_rdata[2]), .a_err_o(a_err[2]),
        .b_req_i(b_off), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_ack_o(b_ack[2]), .b_rdata_o(b_rdata[2]), .b_err_o(b_err[2]),
        .stall_a_o(stall[2]), .busy_o(busy[2]),
        .mem_en_o(me[2]), .mem_we_o(mwe[2]), .mem_addr_o(maddr[2]),
        .mem_wdata_o(mwdata[2]), .mem_rdata_i(mrdata[2]));

    // memory models: read data is driven only in the single cycle LAT after the strobe
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (me[k]) begin
                en_cnt[k]    <= en_cnt[k] + 1;
                last_addr[k] <= maddr[k];
                last_we[k]   <= mwe[k];
            end
            if (me[k] && mwe[k]) mem[k][maddr[k][9:0]] <= mwdata[k];
            if (pend[k] && rem[k] != 0) rem[k] <= rem[k] - 1;
            else if (pend[k]) pend[k] <= 1'b0;
            if (me[k] && !mwe[k]) begin
                pend[k] <= 1'b1;
                rem[k]  <= LAT[k] - 1;
                pdat[k] <= mem[k][maddr[k][9:0]];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) mrdata[k] = (pend[k] && rem[k] == 0) ? pdat[k] : 32'h5A5A_5A5A;
    end

    always @(posedge clk) if (b_ack[0]) back_cnt <= back_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one port-A access on instance k; latency counted from the first IDLE cycle with req high
    task automatic xact(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdo, output logic ero,
                        output logic sok, output int endelta);
        int e0;
        @(posedge clk); #1;
        e0 = en_cnt[k];
        sok = 1'b1;
        a_we = we; a_addr = addr; a_wdata = wd; a_req[k] = 1'b1;
        lat = 0;
        #1;
        while (!a_ack[k] && lat < 40) begin
            if (!stall[k]) sok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (stall[k]) sok = 1'b0;
        rdo = a_rdata[k];
        ero = a_err[k];
        endelta = en_cnt[k] - e0;
        @(negedge clk);
        a_req[k] = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_ctrl", {a_ack[0], b_ack[0], a_err[0], b_err[0], me[0], mwe[0], busy[0], stall[0]}, 8'h00);
        chk("rst_rdata", {a_rdata[0], b_rdata[0]}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        xact(0, 1'b1, 32'd5, 32'hDEAD_BEEF, n, rd, er, st_ok, en_d);
        chk("st5_lat", n, 2);
        chk("st5_en_once", en_d, 1);
        chk("st5_mem", {last_we[0], last_addr[0]}, {1'b1, 32'd5});
        chk("st5_err_stall", {er, st_ok}, 2'b01);

        xact(0, 1'b0, 32'd5, 32'h0, n, rd, er, st_ok, en_d);
        chk("ld5_lat", n, 4);
        chk("ld5_rdata", rd, 32'hDEAD_BEEF);
        chk("ld5_err_stall", {er, st_ok, last_we[0]}, 3'b010);

        xact(0, 1'b0, 32'd1024, 32'h0, n, rd, er, st_ok, en_d);
        chk("oor_lat", n, 1);
        chk("oor_err", er, 1'b1);
        chk("oor_rdata", rd, 32'h0);
        chk("oor_no_mem", en_d, 0);

        xact(0, 1'b1, 32'd1023, 32'hCAFE_F00D, n, rd, er, st_ok, en_d);
        chk("st1023_lat", n, 2);
        xact(0, 1'b0, 32'd1023, 32'h0, n, rd, er, st_ok, en_d);
        chk("ld1023_lat", n, 4);
        chk("ld1023_err", er, 1'b0);
        chk("ld1023_rdata", rd, 32'hCAFE_F00D);

        // B read interrupted by reset while waiting for read data
        @(posedge clk); #1;
        b_we = 1'b0; b_addr = 32'd5; b_req = 1'b1; n = 0;
        @(posedge clk); #1;
        while (!me[0] && n < 10) begin @(posedge clk); #1; n++; end
        chk("b_issue", me[0], 1'b1);
        @(posedge clk); #1;
        chk("b_wait", {busy[0], me[0], b_ack[0]}, 3'b100);
        bcnt0 = back_cnt;
        rst_n = 1'b0;
        #1;
        chk("arst_ctrl", {a_ack[0], b_ack[0], a_err[0], b_err[0], me[0], mwe[0], busy[0], stall[0]}, 8'h00);
        chk("arst_data", {a_rdata[0], b_rdata[0], maddr[0]}, 96'h0);
        b_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        xact(0, 1'b1, 32'd9, 32'h0BAD_CAFE, n, rd, er, st_ok, en_d);
        chk("post_rst_st_lat", n, 2);
        chk("post_rst_no_back", back_cnt - bcnt0, 0);

        // tie straight after reset, both ports held high for four transactions
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        a_we = 1'b0; a_addr = 32'd5; b_we = 1'b0; b_addr = 32'd1023;
        a_req[0] = 1'b1; b_req = 1'b1;
        nack = 0; ovl = 0; n = 0;
        while (nack < 4 && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (a_ack[0] && b_ack[0]) ovl++;
            if (a_ack[0]) begin ord[nack] = 0; rds[nack] = a_rdata[0]; oth[nack] = b_rdata[0]; nack++; end
            else if (b_ack[0]) begin ord[nack] = 1; rds[nack] = b_rdata[0]; oth[nack] = a_rdata[0]; nack++; end
        end
        a_req[0] = 1'b0; b_req = 1'b0;
        chk("rr_count", nack, 4);
        chk("rr_overlap", ovl, 0);
        for (int i = 0; i < nack; i++) begin
            chk($sformatf("rr_order%0d", i), ord[i], i % 2);
            chk($sformatf("rr_rdata%0d", i), rds[i], (i % 2) ? 32'hCAFE_F00D : 32'hDEAD_BEEF);
            chk($sformatf("rr_other0_%0d", i), oth[i], 32'h0);
        end

        // read latency on the MEM_LAT = 1 and MEM_LAT = 5 instances
        xact(1, 1'b1, 32'd7, 32'h1234_5678, n, rd, er, st_ok, en_d);
        chk("l1_st_lat", n, 2);
        xact(1, 1'b0, 32'd7, 32'h0, n, rd, er, st_ok, en_d);
        chk("l1_ld_lat", n, 3);
        chk("l1_ld_rdata", rd, 32'h1234_5678);
        xact(2, 1'b1, 32'd7, 32'h8765_4321, n, rd, er, st_ok, en_d);
        chk("l5_st_lat", n, 2);
        xact(2, 1'b0, 32'd7, 32'h0, n, rd, er, st_ok, en_d);
        chk("l5_ld_lat", n, 7);
        chk("l5_ld_rdata", rd, 32'h8765_4321);
        chk("l5_stall_err", {st_ok, er}, 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Sequences and shares the single-port data memory behind the MEM stage.
- Two requesters:
  - port A: pipeline MEM stage, load/store from AluResult address.
  - port B: auxiliary master, e.g. program loader or I/O.
- Runs one access at a time through an issue/wait/done state machine with fixed read latency, and stalls the pipeline while its access is pending.
- Round-robin arbitration on conflicts; out-of-range addresses are rejected without touching memory.

Parameters:
- ADDR_W, 32, address width, word address.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from mem_en to valid mem_rdata; legal range 1..15.
- DEPTH_WORDS, 1024, number of valid words; an address >= DEPTH_WORDS is an error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  port A request; held with a_we/a_addr/a_wdata stable until a_ack.
- a_we  in  1  1 = store, 0 = load.
- a_addr  in  ADDR_W  word address.
- a_wdata  in  DATA_W  store data.
- a_ack  out  1  one-cycle completion pulse.
- a_rdata  out  DATA_W  load data, valid when a_ack = 1.
- a_err  out  1  valid with a_ack; address out of range.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata, b_err: identical to the A ports, for port B.
- stall_a  out  1  a_req & ~a_ack (combinational); freezes the pipeline.
- busy  out  1  state != IDLE.
- mem_en  out  1  memory access strobe, high exactly one cycle per access.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE, wait counter = 0, last_owner = B.
  - All outputs 0, including all acks, rdata, err, mem_en and mem_we.
  - Takes effect immediately, mid-access included: the in-flight access is abandoned, no ack is produced for it, and any read return is ignored.
- Only registered state drives the outputs, except stall_a.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one requester: grant it.
  - Both requesting: grant the port != last_owner.
  - On grant:
    - latch owner, we, addr, wdata; last_owner <= owner.
    - If addr >= DEPTH_WORDS: go to DONE with err = 1 (no memory access).
    - Otherwise go to ISSUE.
- ISSUE (1 cycle):
  - mem_en = 1; mem_we, mem_addr, mem_wdata come from the latched values.
  - Write: go to DONE.
  - Read: go to WAIT with cnt = MEM_LAT - 1.
- WAIT:
  - cnt != 0: decrement.
  - cnt == 0: this is cycle ISSUE + MEM_LAT. Capture mem_rdata into the rdata register and go to DONE.
- DONE (1 cycle):
  - Owner's ack = 1; owner's rdata = captured data (writes and errors give 0); owner's err as latched.
  - Non-owner outputs stay 0. Next state: IDLE.
- Latency from first IDLE cycle with req high to the ack cycle:
  - write: 2 cycles.
  - read: MEM_LAT + 2 cycles.
  - error: 1 cycle.
- Requester rules:
  - Drop req on the edge after ack. A req still high in IDLE is treated as a new request.
  - Request changes while not owner: honoured at the next IDLE.
  - Fields changing while owner: no effect, values already latched.
- Fairness:
  - With A and B both continuously requesting, grants strictly alternate A, B, A, ...
  - After reset the first tie goes to A.
- mem_en is never high in IDLE, WAIT or DONE. At most one outstanding access.

Test Plan:
- MEM_LAT = 2, A store addr 5 data 0xDEADBEEF:
  - mem_en/mem_we high one cycle, mem_addr = 5; a_ack 2 cycles after req.
  - Then A load addr 5 -> a_ack at 4 cycles, a_rdata = 0xDEADBEEF, a_err = 0; stall_a high every cycle before each ack.
- A and B both request a load in the same IDLE cycle, straight after reset:
  - A served first, then B.
  - With both held continuously for 4 transactions, the ack order is A, B, A, B; no acks overlap.
- A load addr 1024, DEPTH_WORDS = 1024:
  - a_ack and a_err = 1 one cycle later, a_rdata = 0, mem_en never asserted.
  - A following load addr 1023 completes with a_err = 0.
- rst_n pulsed low during WAIT of a B read:
  - All outputs 0 immediately, no b_ack.
  - After release, a new A store completes normally with ack at 2 cycles.
- Repeat the load scenario with MEM_LAT = 1 and MEM_LAT = 5:
  - read ack at 3 and 7 cycles respectively.
  - Captured data equals mem_rdata sampled exactly MEM_LAT cycles after mem_en.
